micro_ram_arbiter: RTL and testbench

- Parametrised multi-port RAM access arbiter for the micro core family.
- Lets NUM_PORTS requesters share one single-port RAM: core data port, debug/loader port, future DMA.
- Round-robin arbitration, req/ack handshake, configurable RAM wait states.
- Instantiated in the micro top between the requesters and the RAM pins (ram_addr / ram_wr_en / ram_data_wr / ram_data_rd).

---
 rtl/micro_ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_micro_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_ram_arbiter.sv
// micro_ram_arbiter: round-robin arbiter letting NUM_PORTS requesters share one single-port RAM.
// Optional per-port bus lock (atomic read-modify-write) is built only when MICRO_ARB_LOCK_EN is defined.
module micro_ram_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0,
  parameter int GRANT_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_PORTS-1:0]            lock,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic                            ram_wr_en,
  output logic [DATA_WIDTH-1:0]           ram_data_wr,
  input  logic [DATA_WIDTH-1:0]           ram_data_rd,
  output logic                            busy,
  output logic [GRANT_W-1:0]              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e                 state_q;
  logic [NUM_PORTS-1:0]   ack_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [ADDR_WIDTH-1:0]  ram_addr_q;
  logic                   ram_wr_en_q;
  logic [DATA_WIDTH-1:0]  ram_data_wr_q;
  logic                   busy_q;
  logic [GRANT_W-1:0]     owner_q;
  logic [GRANT_W-1:0]     ptr_q;
  logic [3:0]             cnt_q;
  logic                   we_q;

  logic [GRANT_W-1:0]     cand;
  logic [GRANT_W-1:0]     win_d;
  logic                   win_vld_d;
  logic                   sel_we_d;
  logic [ADDR_WIDTH-1:0]  sel_addr_d;
  logic [DATA_WIDTH-1:0]  sel_wdata_d;

`ifdef MICRO_ARB_LOCK_EN
  logic                   locked_q;
`else
  logic                   unused_lock;
  assign unused_lock = ^lock;
`endif

  // Search downward so the last hit is the closest port after the pointer.
  always_comb begin
    cand      = '0;
    win_d     = '0;
    win_vld_d = 1'b0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = GRANT_W'((int'(ptr_q) + i) % NUM_PORTS);
      if (req[cand]) begin
        win_d     = cand;
        win_vld_d = 1'b1;
      end
    end
`ifdef MICRO_ARB_LOCK_EN
    if (locked_q && req[owner_q]) begin
      win_d     = owner_q;
      win_vld_d = 1'b1;
    end
`endif
  end

  always_comb begin
    sel_we_d    = 1'b0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (GRANT_W'(i) == win_d) begin
        sel_we_d    = we[i];
        sel_addr_d  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_d = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      ack_q         <= '0;
      rdata_q       <= '0;
      ram_addr_q    <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_data_wr_q <= '0;
      busy_q        <= 1'b0;
      owner_q       <= '0;
      ptr_q         <= GRANT_W'(NUM_PORTS - 1);
      cnt_q         <= '0;
      we_q          <= 1'b0;
`ifdef MICRO_ARB_LOCK_EN
      locked_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
`ifdef MICRO_ARB_LOCK_EN
          if (locked_q && !req[owner_q]) locked_q <= 1'b0;
`endif
          if (win_vld_d) begin
            owner_q       <= win_d;
            ram_addr_q    <= sel_addr_d;
            ram_data_wr_q <= sel_wdata_d;
            we_q          <= sel_we_d;
            cnt_q         <= WAIT_INIT;
            busy_q        <= 1'b1;
            // With no wait states the grant cycle's successor is already the strobe cycle.
            ram_wr_en_q   <= (WAIT_INIT == 4'd0) && sel_we_d;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            ram_wr_en_q <= 1'b0;
            if (!we_q) rdata_q <= ram_data_rd;
            ack_q       <= NUM_PORTS'(1) << owner_q;
            state_q     <= RESP;
          end else begin
            cnt_q       <= cnt_q - 4'd1;
            ram_wr_en_q <= (cnt_q == 4'd1) && we_q;
          end
        end
        RESP: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef MICRO_ARB_LOCK_EN
          if (lock[owner_q]) begin
            locked_q <= 1'b1;
          end else begin
            locked_q <= 1'b0;
            ptr_q    <= owner_q;
          end
`else
          ptr_q   <= owner_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_data_wr = ram_data_wr_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_micro_ram_arbiter.sv
// tb_micro_ram_arbiter: directed bench for micro_ram_arbiter with a transaction-level reference model.
// Main instance uses three ports and one wait state; two small instances cover zero and three wait states.
module tb_micro_ram_arbiter;

  localparam int N  = 3;
  localparam int WS = 1;
`ifdef MICRO_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic [2:0]  req, we, lock;
  logic [23:0] addr, wdata;
  logic [2:0]  ack;
  logic [7:0]  rdata, ramAddr, ramDataWr, ramDataRd;
  logic        ramWrEn, busy;
  logic [1:0]  owner;

  logic [2:0]  req0, we0, ack0, req3, we3, ack3;
  logic [23:0] addr0, wdata0, addr3, wdata3;
  logic [7:0]  rdata0, ramAddr0, ramDataWr0, rdata3, ramAddr3, ramDataWr3;
  logic        ramWrEn0, busy0, ramWrEn3, busy3;
  logic [1:0]  owner0, owner3;

  int nChecks = 0;
  int nPass   = 0;
  bit checkEn = 1'b0;

  logic [7:0] ramMem [256];
  logic [7:0] goldMem [256];

  always #5 clk = ~clk;

  micro_ram_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .arst_n(arst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
    .ack(ack), .rdata(rdata), .ram_addr(ramAddr), .ram_wr_en(ramWrEn), .ram_data_wr(ramDataWr),
    .ram_data_rd(ramDataRd), .busy(busy), .owner(owner));

  micro_ram_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) dutWs0 (
    .clk(clk), .arst_n(arst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .lock(3'b000),
    .ack(ack0), .rdata(rdata0), .ram_addr(ramAddr0), .ram_wr_en(ramWrEn0), .ram_data_wr(ramDataWr0),
    .ram_data_rd(8'hC3), .busy(busy0), .owner(owner0));

  micro_ram_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3)) dutWs3 (
    .clk(clk), .arst_n(arst_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3), .lock(3'b000),
    .ack(ack3), .rdata(rdata3), .ram_addr(ramAddr3), .ram_wr_en(ramWrEn3), .ram_data_wr(ramDataWr3),
    .ram_data_rd(8'hC3), .busy(busy3), .owner(owner3));

  // RAM seen by the main instance: asynchronous read, write on the strobe edge.
  assign ramDataRd = ramMem[ramAddr];
  always @(posedge clk) if (ramWrEn) ramMem[ramAddr] <= ramDataWr;

  // Reference model: one transaction at a time, outputs derived from its cycle index.
  // Cycle 1..WS+1 is the RAM access, WS+2 the ack cycle, WS+3 the idle cycle that samples again.
  bit         mActive = 1'b0;
  bit         mLocked = 1'b0;
  int         mEl = 0, mPtr = N - 1, mOwner = 0;
  bit         mWe = 1'b0;
  logic [7:0] mAddr = '0, mWdata = '0;
  logic [2:0] eAck = '0;
  logic [7:0] eRdata = '0, eAddr = '0, eWdata = '0;
  logic       eWren = 1'b0, eBusy = 1'b0;
  logic [1:0] eOwner = '0;

  always @(posedge clk) begin
    int g;
    if (!arst_n) begin
      mActive = 1'b0; mLocked = 1'b0; mEl = 0; mPtr = N - 1; mOwner = 0;
      eRdata = '0; eAddr = '0; eWdata = '0; eOwner = '0;
    end else if (mActive) begin
      mEl++;
      if (mEl == WS + 2) begin
        if (mWe) goldMem[mAddr] = mWdata;
        else eRdata = goldMem[mAddr];
      end
      if (mEl == WS + 3) begin
        mActive = 1'b0;
        if (LOCK_ON && lock[mOwner]) mLocked = 1'b1;
        else begin
          mLocked = 1'b0;
          mPtr = mOwner;
        end
      end
    end else begin
      g = -1;
      if (LOCK_ON && mLocked) begin
        if (req[mOwner]) g = mOwner;
        else mLocked = 1'b0;
      end
      for (int k = 1; k <= N; k++)
        if (g < 0 && req[(mPtr + k) % N]) g = (mPtr + k) % N;
      if (g >= 0) begin
        mActive = 1'b1; mEl = 1; mOwner = g;
        mWe = we[g]; mAddr = addr[g*8 +: 8]; mWdata = wdata[g*8 +: 8];
        eAddr = mAddr; eWdata = mWdata; eOwner = 2'(g);
      end
    end
    eBusy = mActive;
    eWren = mActive && mWe && (mEl == WS + 1);
    eAck  = (mActive && mEl == WS + 2) ? 3'(1 << mOwner) : 3'b000;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_ack", 32'(ack), 32'(eAck));
      checkOutput("model_rdata", 32'(rdata), 32'(eRdata));
      checkOutput("model_ram_addr", 32'(ramAddr), 32'(eAddr));
      checkOutput("model_ram_wr_en", 32'(ramWrEn), 32'(eWren));
      checkOutput("model_ram_data_wr", 32'(ramDataWr), 32'(eWdata));
      checkOutput("model_busy", 32'(busy), 32'(eBusy));
      checkOutput("model_owner", 32'(owner), 32'(eOwner));
    end
  end

  task automatic applyStimulus(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
    req[p] = 1'b1;
    we[p] = w;
    addr[p*8 +: 8] = a;
    wdata[p*8 +: 8] = d;
  endtask

  // Cycles from the sampling IDLE cycle until ack[p] shows; maxCyc+1 on timeout.
  task automatic waitAck(input int p, input int maxCyc, output int lat, output int wrCnt);
    lat = maxCyc + 1;
    wrCnt = 0;
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      if (ramWrEn) wrCnt++;
      if (ack[p]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic waitAnyAck(input int maxCyc, output int p);
    p = -1;
    for (int k = 1; k <= maxCyc; k++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        checkOutput("ack_onehot", 32'($onehot(ack)), 32'd1);
        for (int j = 0; j < N; j++) if (ack[j]) p = j;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat, wrCnt, p, ackSeen;
    int expOrder[6];
    int expLock[4];
    for (int i = 0; i < 256; i++) begin
      ramMem[i] = '0;
      goldMem[i] = '0;
    end
    arst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    req0 = '0; we0 = '0; addr0 = '0; wdata0 = '0;
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    checkEn = 1'b1;
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_ram_wr_en", 32'(ramWrEn), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_owner", 32'(owner), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);

    // Zero wait states: write from port 0, ack two cycles after sampling.
    req0 = 3'b001; we0 = 3'b001; addr0[7:0] = 8'h40; wdata0[7:0] = 8'h99;
    lat = 11; wrCnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ramWrEn0) begin
        wrCnt++;
        checkOutput("ws0_wr_data", 32'(ramDataWr0), 32'h99);
      end
      if (busy0) checkOutput("ws0_addr_stable", 32'(ramAddr0), 32'h40);
      if (ack0[0]) begin
        lat = k;
        break;
      end
    end
    req0 = '0;
    checkOutput("ws0_ack_latency", 32'(lat), 32'd2);
    checkOutput("ws0_wr_pulses", 32'(wrCnt), 32'd1);

    // Three wait states: read from port 0, ack five cycles after sampling.
    req3 = 3'b001; we3 = 3'b000; addr3[7:0] = 8'h77;
    lat = 11;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy3) checkOutput("ws3_addr_stable", 32'(ramAddr3), 32'h77);
      checkOutput("ws3_no_wr", 32'(ramWrEn3), 32'd0);
      if (ack3[0]) begin
        lat = k;
        checkOutput("ws3_rdata", 32'(rdata3), 32'hC3);
        break;
      end
    end
    req3 = '0;
    checkOutput("ws3_ack_latency", 32'(lat), 32'd5);

    // Port 1 write then read of the same location.
    applyStimulus(1, 1'b1, 8'h10, 8'h5A);
    waitAck(1, 10, lat, wrCnt);
    req = '0;
    checkOutput("wr_ack_latency", 32'(lat), 32'd3);
    checkOutput("wr_strobe_pulses", 32'(wrCnt), 32'd1);
    checkOutput("wr_ram_content", 32'(ramMem[8'h10]), 32'h5A);
    @(negedge clk);
    applyStimulus(1, 1'b0, 8'h10, 8'h00);
    waitAck(1, 10, lat, wrCnt);
    req = '0;
    checkOutput("rd_ack_latency", 32'(lat), 32'd3);
    checkOutput("rd_rdata", 32'(rdata), 32'h5A);
    checkOutput("rd_strobe_pulses", 32'(wrCnt), 32'd0);

    // All ports requesting from a fresh pointer: strict rotation.
    doReset();
    expOrder = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 8'(8'h20 + i), 8'h00);
    for (int a = 0; a < 6; a++) begin
      waitAnyAck(12, p);
      checkOutput($sformatf("rr_grant_%0d", a), 32'(p), 32'(expOrder[a]));
    end
    req = '0;

    // Reset in the middle of a port-2 read: no ack, pointer back to its reset value.
    @(negedge clk);
    applyStimulus(0, 1'b0, 8'h30, 8'h00);
    waitAnyAck(12, p);
    req = '0;
    checkOutput("pre_reset_grant", 32'(p), 32'd0);
    @(negedge clk);
    applyStimulus(2, 1'b0, 8'h22, 8'h00);
    repeat (2) @(negedge clk);
    arst_n = 1'b0;
    req = '0;
    @(negedge clk);
    arst_n = 1'b1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    ackSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack != 3'b000) ackSeen++;
    end
    checkOutput("midreset_no_ack", 32'(ackSeen), 32'd0);
    applyStimulus(1, 1'b0, 8'h21, 8'h00);
    applyStimulus(0, 1'b0, 8'h10, 8'h00);
    waitAnyAck(12, p);
    req = '0;
    checkOutput("post_reset_grant", 32'(p), 32'd0);

    // Port 0 holds lock while everyone requests; lock drops during the third ack.
    doReset();
    if (LOCK_ON) expLock = '{0, 0, 0, 1};
    else expLock = '{0, 1, 2, 0};
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 8'(8'h40 + i), 8'h00);
    lock = 3'b001;
    for (int a = 0; a < 4; a++) begin
      waitAnyAck(12, p);
      checkOutput($sformatf("lock_grant_%0d", a), 32'(p), 32'(expLock[a]));
      if (a == 2) lock = '0;
    end
    req = '0;
    repeat (3) @(negedge clk);
    checkEn = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
